bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
//  Sits upstream of SevSegDisplay: takes a binary count (e.g. from counter_1s) and produces
//  DIGITS packed BCD nibbles, so the display shows decimal instead of hex.
//  Also emits a leading-zero mask so the consumer can blank unused high digits.
// PARAMETERS
//  WIDTH   27  binary input width; 27 bits covers 0..99_999_999
//  DIGITS  8   BCD output digits; MAX = 10**DIGITS-1
// PORTS
//  clock     in   1           system clock, all state on rising edge
//  reset     in   1           asynchronous, active-high; clears all state
//  in_valid  in   1           bin is valid; accepted on an edge where in_valid && in_ready
//  in_ready  out  1           high only in IDLE
//  bin       in   WIDTH       unsigned binary value to convert
//  bcd       out  4*DIGITS    result; nibble i = digit i; [3:0] is the least-significant digit
//  digit_en  out  DIGITS      bit i=1 if digit i is at or below the most-significant non-zero digit; bit0 always 1
//  overflow  out  1           last accepted bin exceeded MAX (saturated)
//  out_valid out  1           one-cycle pulse: bcd/digit_en/overflow just updated
// BEHAVIOUR
//  Reset values: bcd=0, digit_en='b1, overflow=0, out_valid=0.
//  Reset values (cont.): FSM=IDLE, so in_ready=1; shift and scratch registers = 0.
//  Reset mid-conversion aborts it; outputs return to reset values immediately (async).
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On accept (edge E0): capture min(bin,MAX) into the shift register.
//   - Also at E0: latch ovf_pending=(bin>MAX), clear the scratch BCD register, set bit count=WIDTH, go to SHIFT.
//  SHIFT:
//   - Each edge: every scratch nibble >=5 gets +3 (all nibbles in parallel, on pre-shift values).
//   - Same edge: {scratch,shift} shifted left by 1; the shift-register MSB enters scratch bit0.
//   - Exactly WIDTH shifts, at edges E1..E_WIDTH; at E_WIDTH go to DONE.
//  DONE:
//   - in_ready=0.
//   - At edge E_(WIDTH+1): bcd<=scratch, overflow<=ovf_pending, digit_en<=computed mask, out_valid<=1.
//   - Same edge: go to IDLE.
//  out_valid is high in the cycle after E_(WIDTH+1), the same cycle in which in_ready is 1 again.
//  Latency: WIDTH+1 clocks from accept edge to out_valid edge; throughput 1 per WIDTH+2 clocks.
//  in_valid while in_ready=0 is ignored (no queueing); bin may change freely while busy.
//  Outputs hold their last result between conversions (no glitch; all update on one edge).
//  Saturation: bin>MAX converts MAX (all nibbles 9) and sets overflow; the scratch never needs >DIGITS nibbles.
//  The +3 adjust keeps every nibble <=9 after each shift; no nibble carry logic.
//  digit_en: thermometer from the highest non-zero nibble down to bit0; value 0 -> 'b0..01.
//  in_valid asserted in the same cycle as out_valid: accepted normally (back-to-back).
// TESTING
//  bin=0 -> after 28 clk: bcd=32'h0000_0000, digit_en=8'b0000_0001, overflow=0, one out_valid pulse.
//  bin=12_345_678 -> bcd=32'h1234_5678, digit_en=8'hFF; out_valid exactly 28 clocks after the accept edge.
//  bin=99_999_999 -> bcd=32'h9999_9999, overflow=0.
//  bin=100_000_000 -> bcd=32'h9999_9999, overflow=1.
//  bin=2**27-1 -> bcd=32'h9999_9999, overflow=1.
//  bin=1_005 -> bcd=32'h0000_1005, digit_en=8'b0000_1111.
//  in_valid held high with bin changing -> only values present on in_ready=1 edges are converted.
//  Held-valid case (cont.): conversions are spaced 29 clocks apart; in_ready=0 throughout SHIFT/DONE.
//  Reset asserted during SHIFT (bit 10) -> all outputs go to reset values at once, in_ready=1.
//  After that reset, bin=42 -> bcd=32'h0000_0042, digit_en=8'b0000_0011.
//  Random 1000 values 0..2**27-1 vs reference model: bcd, overflow and digit_en all match.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Feeds a seven-segment display so counts show as decimal. It also produces a
// leading-zero mask so unused high digits can be blanked. Values above the largest
// representable decimal number saturate to all nines and raise overflow.
module bin2bcd_seq #(
    parameter int WIDTH  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  overflow,
    output logic                  out_valid
);

    localparam int              BCD_W   = 4 * DIGITS;
    localparam int              CNT_W   = $clog2(WIDTH + 1);
    localparam logic [63:0]     MAX_VAL = 64'(10 ** DIGITS) - 64'd1;
    localparam logic [WIDTH-1:0] MAX_BIN = MAX_VAL[WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } stateT;

    stateT              r_state;
    logic [CNT_W-1:0]   r_bitCount;
    logic [WIDTH-1:0]   r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic               r_ovfPending;

    logic [63:0]        w_binWide;
    logic               w_overMax;
    logic [BCD_W-1:0]   w_adjusted;
    logic [DIGITS-1:0]  w_digitMask;

    assign in_ready  = (r_state == IDLE);
    assign w_binWide = 64'(bin);
    assign w_overMax = (w_binWide > MAX_VAL);

    // Add 3 to every scratch nibble that is 5 or more, so the next shift carries correctly into the next digit
    always_comb begin
        w_adjusted = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adjusted[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Thermometer mask: enable every digit from the highest non-zero one down to digit 0
    always_comb begin : maskComb
        logic seen;
        seen        = 1'b0;
        w_digitMask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (r_scratch[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            w_digitMask[i] = seen;
        end
        w_digitMask[0] = 1'b1;
    end

    // Conversion FSM: accept a value, shift it in over WIDTH clocks, then publish all outputs together
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_bitCount   <= '0;
            r_shift      <= '0;
            r_scratch    <= '0;
            r_ovfPending <= 1'b0;
            bcd          <= '0;
            digit_en     <= DIGITS'(1);
            overflow     <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift      <= w_overMax ? MAX_BIN : bin;
                        r_ovfPending <= w_overMax;
                        r_scratch    <= '0;
                        r_bitCount   <= CNT_W'(WIDTH);
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch  <= {w_adjusted[BCD_W-2:0], r_shift[WIDTH-1]};
                    r_shift    <= {r_shift[WIDTH-2:0], 1'b0};
                    r_bitCount <= r_bitCount - CNT_W'(1);
                    if (r_bitCount == CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    bcd       <= r_scratch;
                    overflow  <= r_ovfPending;
                    digit_en  <= w_digitMask;
                    out_valid <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random stimulus for bin2bcd_seq, checked every cycle
// against a decimal-arithmetic model plus hand-computed literal expectations.
module tb_bin2bcd_seq;

    localparam int          WIDTH  = 27;
    localparam int          DIGITS = 8;
    localparam int unsigned MAX    = 99_999_999;

    logic                 clock;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     bin;
    logic [4*DIGITS-1:0]  bcd;
    logic [DIGITS-1:0]    digit_en;
    logic                 overflow;
    logic                 out_valid;

    int checks = 0;
    int passes = 0;

    // Model state
    int               busyLeft  = 0;
    logic [WIDTH-1:0] pendVal   = '0;
    logic [31:0]      expBcd    = '0;
    logic [7:0]       expEn     = 8'h01;
    logic             expOvf    = 1'b0;
    logic             expValid  = 1'b0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .bcd       (bcd),
        .digit_en  (digit_en),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] refBcd(input int unsigned v);
        int unsigned s;
        logic [31:0] r;
        s = (v > MAX) ? MAX : v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] refEn(input int unsigned v);
        int unsigned s;
        int top;
        logic [7:0] r;
        s = (v > MAX) ? MAX : v;
        top = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s % 10 != 0) top = i;
            s = s / 10;
        end
        r = '0;
        for (int i = 0; i <= top; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Cycle-level model: idle until a value arrives, busy for WIDTH+1 edges, then publish the decimal result
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            busyLeft <= 0;
            expBcd   <= '0;
            expEn    <= 8'h01;
            expOvf   <= 1'b0;
            expValid <= 1'b0;
        end else begin
            expValid <= 1'b0;
            if (busyLeft == 0) begin
                if (in_valid) begin
                    pendVal  <= bin;
                    busyLeft <= WIDTH + 1;
                end
            end else begin
                busyLeft <= busyLeft - 1;
                if (busyLeft == 1) begin
                    expBcd   <= refBcd(32'(pendVal));
                    expEn    <= refEn(32'(pendVal));
                    expOvf   <= (32'(pendVal) > MAX);
                    expValid <= 1'b1;
                end
            end
        end
    end

    // Compare every DUT output against the model on the falling edge
    always @(negedge clock) begin
        checkOutput("cyc_bcd", bcd, expBcd);
        checkOutput("cyc_digit_en", 32'(digit_en), 32'(expEn));
        checkOutput("cyc_overflow", 32'(overflow), 32'(expOvf));
        checkOutput("cyc_out_valid", 32'(out_valid), 32'(expValid));
        checkOutput("cyc_in_ready", 32'(in_ready), 32'(busyLeft == 0));
    end

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 60) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (guard >= 60) checkOutput("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] value, output int latency);
        waitIdle();
        in_valid = 1'b1;
        bin      = value;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        bin      = WIDTH'($urandom);
        latency  = 0;
        while (out_valid !== 1'b1 && latency < 40) begin
            @(posedge clock);
            #1;
            latency++;
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] value;
        logic [31:0]      bcdExp;
        logic [7:0]       enExp;
        logic             ovfExp;
    } vecT;

    vecT vectors[6];

    initial begin
        int lat;
        int pulses;
        int lastPulse;
        logic [31:0] firstBcd;
        logic [31:0] secondBcd;
        int spacing;

        vectors[0] = '{27'd0,           32'h0000_0000, 8'b0000_0001, 1'b0};
        vectors[1] = '{27'd12_345_678,  32'h1234_5678, 8'hFF,        1'b0};
        vectors[2] = '{27'd99_999_999,  32'h9999_9999, 8'hFF,        1'b0};
        vectors[3] = '{27'd100_000_000, 32'h9999_9999, 8'hFF,        1'b1};
        vectors[4] = '{27'h7FF_FFFF,    32'h9999_9999, 8'hFF,        1'b1};
        vectors[5] = '{27'd1_005,       32'h0000_1005, 8'b0000_1111, 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        bin      = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_bcd", bcd, 32'h0);
        checkOutput("rst_digit_en", 32'(digit_en), 32'h1);
        checkOutput("rst_overflow", 32'(overflow), 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vectors[v].value, lat);
            checkOutput("dir_latency", 32'(lat), 32'd28);
            checkOutput("dir_bcd", bcd, vectors[v].bcdExp);
            checkOutput("dir_digit_en", 32'(digit_en), 32'(vectors[v].enExp));
            checkOutput("dir_overflow", 32'(overflow), 32'(vectors[v].ovfExp));
        end

        waitIdle();
        pulses    = 0;
        lastPulse = 0;
        spacing   = 0;
        firstBcd  = '0;
        secondBcd = '0;
        for (int k = 0; k < 90; k++) begin
            in_valid = 1'b1;
            bin      = WIDTH'(500 + 7 * k);
            @(posedge clock);
            #1;
            if (out_valid === 1'b1) begin
                if (pulses == 0) firstBcd = bcd;
                if (pulses == 1) begin
                    secondBcd = bcd;
                    spacing   = k - lastPulse;
                end
                lastPulse = k;
                pulses++;
            end
        end
        in_valid = 1'b0;
        checkOutput("held_pulses", 32'(pulses), 32'd3);
        checkOutput("held_spacing", 32'(spacing), 32'd29);
        checkOutput("held_first", firstBcd, 32'h0000_0500);
        checkOutput("held_second", secondBcd, 32'h0000_0703);

        waitIdle();
        in_valid = 1'b1;
        bin      = 27'd123_456;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("abort_bcd", bcd, 32'h0);
        checkOutput("abort_digit_en", 32'(digit_en), 32'h1);
        checkOutput("abort_overflow", 32'(overflow), 32'h0);
        checkOutput("abort_out_valid", 32'(out_valid), 32'h0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'h1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        applyStimulus(27'd42, lat);
        checkOutput("post_latency", 32'(lat), 32'd28);
        checkOutput("post_bcd", bcd, 32'h0000_0042);
        checkOutput("post_digit_en", 32'(digit_en), 32'h03);

        waitIdle();
        pulses = 0;
        for (int k = 0; k < 29000; k++) begin
            in_valid = 1'b1;
            bin      = WIDTH'($urandom);
            @(posedge clock);
            #1;
            if (out_valid === 1'b1) pulses++;
        end
        in_valid = 1'b0;
        checkOutput("rand_pulses", 32'(pulses), 32'd1000);

        repeat (35) @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
